// File: rtl/guarded_fifo_pkg.sv
// Shared defaults and sizing helper for the guarded synchronous FIFO.
package guarded_fifo_pkg;

  localparam int unsigned DEFAULT_DATA_W = 8;
  localparam int unsigned DEFAULT_DEPTH  = 16;

  // Bits needed to hold an occupancy value in 0..depth inclusive.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage : guarded_fifo_pkg

// File: rtl/fifo_ptr_ctr.sv
// Wrapping address pointer for the FIFO storage; advances on inc, wraps DEPTH-1 -> 0.
module fifo_ptr_ctr #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inc,
  output logic [$clog2(DEPTH)-1:0] ptr
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
    end
  end

endmodule : fifo_ptr_ctr

// File: rtl/guarded_sync_fifo.sv
// Single-clock FIFO that drops illegal requests and records them in sticky error flags.
module guarded_sync_fifo
  import guarded_fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = DEFAULT_DATA_W,
  parameter int unsigned DEPTH     = DEFAULT_DEPTH,
  parameter int unsigned AF_THRESH = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       err_clr
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = count_width(DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              wr_acc_c;
  logic              rd_acc_c;
  logic [CNT_W-1:0]  count_next_c;

  // Acceptance uses only the registered flags, so a full+read cycle still drops the write.
  assign wr_acc_c     = wr_en && !full;
  assign rd_acc_c     = rd_en && !empty;
  assign count_next_c = count + CNT_W'(wr_acc_c) - CNT_W'(rd_acc_c);

  fifo_ptr_ctr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (wr_acc_c),
    .ptr (wr_ptr)
  );

  fifo_ptr_ctr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (rd_acc_c),
    .ptr (rd_ptr)
  );

  // Storage is intentionally not reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc_c) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc_c;
      if (rd_acc_c) begin
        rd_data <= mem[rd_ptr];
      end
    end
  end

  // Flags follow count_next so they always agree with the registered count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      almost_full <= 1'b0;
    end else begin
      count       <= count_next_c;
      full        <= (count_next_c == CNT_FULL);
      empty       <= (count_next_c == '0);
      almost_full <= (count_next_c >= CNT_AF);
    end
  end

  // A new error outranks a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
      end
    end
  end

  a_count_range: assert property (@(posedge clk) disable iff (rst) count <= CNT_FULL);
  a_not_full_and_empty: assert property (@(posedge clk) disable iff (rst) !(full && empty));
  a_wr_acc_not_full: assert property (@(posedge clk) disable iff (rst) wr_acc_c |-> !full);
  a_rd_valid_follows_read: assert property (@(posedge clk) disable iff (rst)
    rd_valid |-> $past(rd_acc_c));

endmodule : guarded_sync_fifo

// File: doc/guarded_sync_fifo.md
GUARDED_SYNC_FIFO -- requirements
Module: guarded_sync_fifo

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, number of entries (power of two, >=2).
REQ-003 Parameter AF_THRESH, default DEPTH-2, occupancy at or above which almost_full asserts (1..DEPTH).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 wr_en  input  1  write request.
REQ-007 wr_data  input  DATA_W  write data, sampled with wr_en.
REQ-008 rd_en  input  1  read request.
REQ-009 rd_data  output  DATA_W  registered read data.
REQ-010 rd_valid  output  1  rd_data holds a newly popped word this cycle.
REQ-011 full  output  1  count == DEPTH.
REQ-012 empty  output  1  count == 0.
REQ-013 almost_full  output  1  count >= AF_THRESH.
REQ-014 count  output  $clog2(DEPTH+1)  current occupancy.
REQ-015 overflow  output  1  sticky: a write was attempted while full.
REQ-016 underflow  output  1  sticky: a read was attempted while empty.
REQ-017 err_clr  input  1  clears overflow and underflow.

Function
REQ-018 Write accepted = wr_en && !full; read accepted = rd_en && !empty; both use the flags registered at the start of the cycle.
REQ-019 An accepted write stores wr_data at wr_ptr; wr_ptr advances by 1, wrapping DEPTH-1 -> 0.
REQ-020 An accepted read registers mem[rd_ptr] into rd_data and asserts rd_valid on the following cycle; rd_ptr advances by 1, wrapping DEPTH-1 -> 0; read latency is exactly 1 cycle.
REQ-021 rd_valid is low in any cycle not following an accepted read; rd_data holds its last value when no read is accepted.
REQ-022 count_next = count + wr_acc - rd_acc; no other count updates are permitted; count never exceeds DEPTH and never underflows.
REQ-023 Simultaneous read and write while neither full nor empty: both are accepted, count unchanged.
REQ-024 Simultaneous read and write while full: read accepted, write dropped, overflow set, count decrements by 1.
REQ-025 Simultaneous read and write while empty: write accepted, read dropped, underflow set, count becomes 1, rd_valid stays low.
REQ-026 A dropped write leaves memory, wr_ptr and count unchanged; a dropped read leaves rd_ptr, rd_data and count unchanged.
REQ-027 full, empty and almost_full are registered and derived from count_next, so they are consistent with count every cycle.
REQ-028 overflow/underflow set on the cycle after a dropped request and stay set until err_clr; a new error in the same cycle as err_clr takes priority (the flag stays set).

Reset
REQ-029 rst asserted immediately forces wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_full=0 (AF_THRESH>=1), rd_valid=0, rd_data=0, overflow=0, underflow=0.
REQ-030 Memory contents are not reset; a reset mid-operation discards all stored words and aborts any pending rd_valid.
REQ-031 Requests on the first edge after rst deasserts are handled normally.

Structure
REQ-032 Package guarded_fifo_pkg holds the default DATA_W/DEPTH constants and a count-width helper function.
REQ-033 Sub-module fifo_ptr_ctr (wrapping pointer with increment enable, async active-high reset) is instantiated twice, for wr_ptr and rd_ptr.
REQ-034 The block carries concurrent assertions disabled during rst: count in range, never full&&empty, wr_acc implies !full, and rd_valid implies a read was accepted on the previous cycle.

Verification
REQ-035 Reset check: assert rst mid-stream with count=5 -> count=0, empty=1, rd_valid=0 with no clock edge.
REQ-036 Fill/drain (DATA_W=8, DEPTH=16): write 0x00..0x0F -> full=1, almost_full asserted at count=14; 16 reads -> data 0x00..0x0F in order, each one cycle after its rd_en, empty=1 at the end.
REQ-037 Overflow: 17th write while full -> dropped, overflow=1, count=16; err_clr pulse -> overflow=0.
REQ-038 Underflow: rd_en while empty -> underflow=1, rd_valid=0, count=0.
REQ-039 Simultaneous: rd_en+wr_en at count=16 -> count=15, overflow=1; at count=0 -> count=1, underflow=1; at count=7 -> count=7.
REQ-040 Wrap: 40 interleaved writes/reads with count held between 1 and 3 -> both pointers wrap at least twice, with data order preserved.
